// File: rtl/wb_regfile.sv
// Write-back end of the MEM/WB stage: picks the write-back value, updates the 8x8 register file,
// serves two bypassed decode read ports, and stalls decode on load-use hazards.
module wb_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memToRegWB,
  input  logic              regWriteWB,
  input  logic [DATA_W-1:0] readDataWB,
  input  logic [DATA_W-1:0] aluResWB,
  input  logic [ADDR_W-1:0] rdWB,
  input  logic [ADDR_W-1:0] rs1Addr,
  input  logic [ADDR_W-1:0] rs2Addr,
  output logic [DATA_W-1:0] rs1Data,
  output logic [DATA_W-1:0] rs2Data,
  input  logic              issueValid,
  input  logic              issueLoad,
  input  logic [ADDR_W-1:0] issueRd,
  output logic              stall,
  output logic [DATA_W-1:0] wbData,
  output logic              wbWrite
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pend_nxt;
  logic              w_ld_clr;
  logic              w_ld_set;
  logic              w_hit1;
  logic              w_hit2;

  assign wbData  = memToRegWB ? readDataWB : aluResWB;
  assign wbWrite = regWriteWB && (rdWB != '0);

  assign rs1Data = (rs1Addr == '0) ? '0 :
                   (wbWrite && rdWB == rs1Addr) ? wbData : r_regs[rs1Addr];
  assign rs2Data = (rs2Addr == '0) ? '0 :
                   (wbWrite && rdWB == rs2Addr) ? wbData : r_regs[rs2Addr];

  // A load returning this cycle releases its register; its data is already on the bypass path.
  assign w_ld_clr = wbWrite && memToRegWB;
  assign w_hit1   = (rs1Addr != '0) && r_pending[rs1Addr] && !(w_ld_clr && rdWB == rs1Addr);
  assign w_hit2   = (rs2Addr != '0) && r_pending[rs2Addr] && !(w_ld_clr && rdWB == rs2Addr);
  assign stall    = issueValid && (w_hit1 || w_hit2);
  assign w_ld_set = issueValid && issueLoad && !stall && (issueRd != '0);

  // Set is applied after clear so a newly issued load keeps ownership of its register.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_ld_clr) w_pend_nxt[rdWB] = 1'b0;
    if (w_ld_set) w_pend_nxt[issueRd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_pending <= '0;
    end else begin
      if (wbWrite) r_regs[rdWB] <= wbData;
      r_pending <= w_pend_nxt;
    end
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register in the 8-bit pipelined core.
- Selects write-back data, writes the 8x8 register file, and serves two decode-stage read ports with write-through bypass.
- Holds a load scoreboard that raises a stall on load-use hazards until the load's data reaches write-back.
- Sits between the MEM/WB register outputs and the ID stage.

Parameters:
- DATA_W, 8, register and data width in bits.
- ADDR_W, 3, register address width; register count = 2**ADDR_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- memToRegWB  input  1  write-back source select: 1 = readDataWB, 0 = aluResWB.
- regWriteWB  input  1  write-back enable.
- readDataWB  input  DATA_W  load data from MEM/WB.
- aluResWB  input  DATA_W  ALU result from MEM/WB.
- rdWB  input  ADDR_W  write-back destination register.
- rs1Addr  input  ADDR_W  ID read port 1 address.
- rs2Addr  input  ADDR_W  ID read port 2 address.
- rs1Data  output  DATA_W  read port 1 data.
- rs2Data  output  DATA_W  read port 2 data.
- issueValid  input  1  ID presents an instruction this cycle.
- issueLoad  input  1  the presented instruction is a load.
- issueRd  input  ADDR_W  destination register of the presented instruction.
- stall  output  1  ID must hold; the instruction is not accepted.
- wbData  output  DATA_W  selected write-back value, for forwarding.
- wbWrite  output  1  effective write this cycle (regWriteWB && rdWB != 0).

Behaviour:
- Reset is asynchronous. All registers R0..R7 go to 0 and all scoreboard pending bits clear. A reset asserted mid-operation discards every in-flight pending bit. stall reads 0 while rst is high.
- wbData = memToRegWB ? readDataWB : aluResWB. Purely combinational, no latency.
- Write: on rising clk, if wbWrite then reg[rdWB] <= wbData. A write to R0 is ignored, so R0 always reads 0.
- Reads are combinational. Address 0 returns 0. If wbWrite and rdWB == rsXAddr, return wbData (bypass, same cycle). Otherwise return reg[rsXAddr].
- Both ports read the same address independently and return identical data.
- Scoreboard: one pending bit per register; bit 0 is never set.
- Clear: on rising clk, if wbWrite && memToRegWB, pending[rdWB] <= 0.
- Set: on rising clk, if issueValid && issueLoad && !stall && issueRd != 0, pending[issueRd] <= 1.
- Set and clear of the same register in the same cycle: set wins, because a new load owns the register.
- Clearing one register and setting a different one in the same cycle both take effect.
- hitX = (rsXAddr != 0) && pending[rsXAddr] && !(wbWrite && memToRegWB && rdWB == rsXAddr). The released data is bypassed in that cycle.
- stall = issueValid && (hit1 || hit2). Combinational.
- A stalled instruction changes no scoreboard state; ID re-presents it on the next cycle.
- A non-load write-back (memToRegWB = 0) never clears a pending bit.
- Two loads to the same rd: the bit stays set until a load write-back to that rd. The team's pipeline orders loads in-order, so the first write-back clears it.
- issueValid = 0 forces stall to 0 regardless of the address inputs.

Test Plan:
- Reset then read: pulse rst; rs1Addr=3, rs2Addr=0 -> rs1Data=0x00, rs2Data=0x00, stall=0.
- ALU write-back: regWriteWB=1, memToRegWB=0, aluResWB=0x5A, rdWB=2, rs1Addr=2 -> rs1Data=0x5A in the same cycle (bypass). After the edge, with regWriteWB=0, rs1Data=0x5A from storage.
- R0 protection: regWriteWB=1, rdWB=0, aluResWB=0xFF -> wbWrite=0; rs1Addr=0 reads 0x00 before and after the edge.
- Load-use stall: issue load issueRd=4 -> pending[4]. Next cycle issueValid=1, rs2Addr=4 -> stall=1 while held. Then apply write-back memToRegWB=1, readDataWB=0xC3, rdWB=4 -> stall=0 in that cycle, rs2Data=0xC3; after the edge pending[4]=0.
- Set/clear collision: load write-back rdWB=5 and a new load issueRd=5 on the same edge -> pending[5] remains 1; a later read of 5 with issueValid=1 gives stall=1.
- Reset mid-operation: pending[3]=1 and reg[3]=0x77; assert rst asynchronously between edges -> stall=0 immediately, rs1Addr=3 reads 0x00.
